// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-to-serial transmitter feeding the pair detector's serial input.
// Accepts a WIDTH-bit word on load/ready and shifts it out MSB first, one bit per clock.
// After each word it inserts GAP idle cycles before it accepts the next word.
// Optional even-parity bit after the LSB: define SERIAL_PATTERN_TX_PARITY_EN.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             outbits,
    output logic             out_valid,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W = 4;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        ST_PARITY = 2'd3,
`endif
        ST_GAP    = 2'd2
    } state_e;

    // State entered once the last bit of a word (data or parity) has gone out
    localparam state_e POST_WORD = (GAP > 0) ? ST_GAP : ST_IDLE;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic             ready_q,     ready_d;
    logic             outbits_q,   outbits_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q,      done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             parity_q,    parity_d;
`endif

    // Next-state, datapath and next-output computation; outputs are decoded from next state
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d   = d;
                    bit_cnt_d = BIT_LAST;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    parity_d  = ^d;
`endif
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                if (bit_cnt_q == '0) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_d   = ST_PARITY;
`else
                    state_d   = POST_WORD;
                    gap_cnt_d = GAP_LAST;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
            ST_PARITY: begin
                state_d   = POST_WORD;
                gap_cnt_d = GAP_LAST;
            end
`endif

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d     = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_SHIFT);
        outbits_d   = (state_d == ST_SHIFT) && shift_d[WIDTH-1];
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        out_valid_d = out_valid_d || (state_d == ST_PARITY);
        outbits_d   = outbits_d || ((state_d == ST_PARITY) && parity_d);
        done_d      = (state_d == ST_PARITY);
`else
        done_d      = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
`endif
    end

    // State, datapath and output registers; synchronous reset aborts any word in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b1;
            outbits_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ready_q     <= ready_d;
            outbits_q   <= outbits_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign outbits   = outbits_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (GAP=1 and GAP=0), a timing-rule reference model,
// a per-cycle compare process, directed scenarios with literal expectations, and random traffic.
module tb_serial_pattern_tx;

    localparam int W  = 5;
    localparam int GA = 1;
    localparam int GB = 0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PER = W + GA + 1 + P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_a = 1'b1, load_a = 1'b0;
    logic [W-1:0] d_a = '0;
    logic         ready_a, outbits_a, out_valid_a, done_a;
    logic         reset_b = 1'b1, load_b = 1'b0;
    logic [W-1:0] d_b = '0;
    logic         ready_b, outbits_b, out_valid_b, done_b;

    serial_pattern_tx #(.WIDTH(W), .GAP(GA)) dut_a (
        .clk(clk), .reset(reset_a), .d(d_a), .load(load_a),
        .ready(ready_a), .outbits(outbits_a), .out_valid(out_valid_a), .done(done_a)
    );

    serial_pattern_tx #(.WIDTH(W), .GAP(GB)) dut_b (
        .clk(clk), .reset(reset_b), .d(d_b), .load(load_b),
        .ready(ready_b), .outbits(outbits_b), .out_valid(out_valid_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference model: a word accepted at an edge is described by the edge count after it;
    // every output follows from the elapsed cycle count t since acceptance.
    int           ecount = 0;
    bit           act[2];
    int           acc[2];
    logic [W-1:0] wrd[2];
    bit           check_en = 1'b0;

    function automatic int gap_of(input int i);
        return (i == 0) ? GA : GB;
    endfunction

    // Returns {outbits, out_valid, done, ready} expected in the current cycle
    function automatic logic [3:0] model_out(input int i);
        int   t;
        logic ob, ov, dn, rd;
        ob = 1'b0; ov = 1'b0; dn = 1'b0; rd = 1'b1;
        if (act[i]) begin
            t = ecount - acc[i];
            if (t < W) begin
                ob = wrd[i][W-1-t];
                ov = 1'b1;
                dn = (P == 0) && (t == W - 1);
                rd = 1'b0;
            end else if ((P == 1) && (t == W)) begin
                ob = ^wrd[i];
                ov = 1'b1;
                dn = 1'b1;
                rd = 1'b0;
            end else if (t < W + P + gap_of(i)) begin
                rd = 1'b0;
            end
        end
        return {ob, ov, dn, rd};
    endfunction

    // Model update at each active edge: reset wins, otherwise accept when the model says ready
    always @(posedge clk) begin
        logic [3:0]   m;
        logic         rst, ld;
        logic [W-1:0] din;
        for (int i = 0; i < 2; i++) begin
            m   = model_out(i);
            rst = (i == 0) ? reset_a : reset_b;
            ld  = (i == 0) ? load_a  : load_b;
            din = (i == 0) ? d_a     : d_b;
            if (rst) begin
                act[i] = 1'b0;
            end else if (ld && m[0]) begin
                act[i] = 1'b1;
                acc[i] = ecount + 1;
                wrd[i] = din;
            end
        end
        ecount++;
    end

    // Per-cycle comparison of both instances against the model, away from the active edge
    always @(negedge clk) begin
        logic [3:0] m;
        logic [3:0] g;
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                m = model_out(i);
                g = (i == 0) ? {outbits_a, out_valid_a, done_a, ready_a}
                             : {outbits_b, out_valid_b, done_b, ready_b};
                chk($sformatf("inst%0d.outbits@%0d",   i, ecount), 32'(g[3]), 32'(m[3]));
                chk($sformatf("inst%0d.out_valid@%0d", i, ecount), 32'(g[2]), 32'(m[2]));
                chk($sformatf("inst%0d.done@%0d",      i, ecount), 32'(g[1]), 32'(m[1]));
                chk($sformatf("inst%0d.ready@%0d",     i, ecount), 32'(g[0]), 32'(m[0]));
            end
        end
    end

    // Sends one word on instance A from an idle negedge and records 8 cycles (N+1..N+8), first in MSB
    task automatic run_word(input logic [W-1:0] w, input int pulse_at, input logic [W-1:0] pw,
                            input int rst_at,
                            output logic [7:0] ob, output logic [7:0] ov,
                            output logic [7:0] dn, output logic [7:0] rd);
        ob = '0; ov = '0; dn = '0; rd = '0;
        d_a    = w;
        load_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            ob = {ob[6:0], outbits_a};
            ov = {ov[6:0], out_valid_a};
            dn = {dn[6:0], done_a};
            rd = {rd[6:0], ready_a};
            if (k == 0) load_a = 1'b0;
            if (k == pulse_at) begin
                load_a = 1'b1;
                d_a    = pw;
            end
            if (k == pulse_at + 1) load_a = 1'b0;
            if (k == rst_at) reset_a = 1'b1;
            if (k == rst_at + 1) reset_a = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0]  ob, ov, dn, rd;
        logic [7:0]  e_ob, e_ov, e_dn, e_rd;
        logic [13:0] vb, vv, e_vb, e_vv;
        int          pairs, dones;
        logic        prev;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
        e_ob = 8'b10110100; e_ov = 8'b11111100; e_dn = 8'b00000100; e_rd = 8'b00000001;
        e_vb = 14'b10000100001100; e_vv = 14'b11111101111110;
`else
        e_ob = 8'b10110000; e_ov = 8'b11111000; e_dn = 8'b00001000; e_rd = 8'b00000011;
        e_vb = 14'b10000000011000; e_vv = 14'b11111011111000;
`endif

        repeat (2) @(negedge clk);
        reset_a  = 1'b0;
        reset_b  = 1'b0;
        check_en = 1'b1;

        // Reset state
        chk("reset.ready_a",     32'(ready_a),     32'd1);
        chk("reset.outbits_a",   32'(outbits_a),   32'd0);
        chk("reset.out_valid_a", 32'(out_valid_a), 32'd0);
        chk("reset.done_a",      32'(done_a),      32'd0);
        chk("reset.ready_b",     32'(ready_b),     32'd1);

        // Basic word 10110
        repeat (2) @(negedge clk);
        run_word(5'b10110, -1, 5'b00000, -1, ob, ov, dn, rd);
        chk("w10110.outbits",   32'(ob), 32'(e_ob));
        chk("w10110.out_valid", 32'(ov), 32'(e_ov));
        chk("w10110.done",      32'(dn), 32'(e_dn));
        chk("w10110.ready",     32'(rd), 32'(e_rd));

        // Load pulse during a word in flight is ignored
        repeat (3) @(negedge clk);
        run_word(5'b10110, 2, 5'b00001, -1, ob, ov, dn, rd);
        chk("ignored.outbits", 32'(ob), 32'(e_ob));
        chk("ignored.done",    32'(dn), 32'(e_dn));

        // Reset in cycle N+3 aborts the word
        repeat (3) @(negedge clk);
        run_word(5'b10101, -1, 5'b00000, 2, ob, ov, dn, rd);
        chk("abort.outbits",   32'(ob), 32'(8'b10100000));
        chk("abort.out_valid", 32'(ov), 32'(8'b11100000));
        chk("abort.done",      32'(dn), 32'(8'b00000000));
        chk("abort.ready",     32'(rd), 32'(8'b00011111));

        // Fresh word after the abort
        repeat (2) @(negedge clk);
        run_word(5'b10110, -1, 5'b00000, -1, ob, ov, dn, rd);
        chk("fresh.outbits", 32'(ob), 32'(e_ob));
        chk("fresh.done",    32'(dn), 32'(e_dn));

        // Reset and load on the same edge: word dropped
        repeat (3) @(negedge clk);
        reset_a = 1'b1; load_a = 1'b1; d_a = 5'b11111;
        @(negedge clk);
        reset_a = 1'b0; load_a = 1'b0;
        chk("rst_load.ready",     32'(ready_a),     32'd1);
        chk("rst_load.out_valid", 32'(out_valid_a), 32'd0);
        @(negedge clk);
        chk("rst_load.out_valid2", 32'(out_valid_a), 32'd0);

        // Load held high with 11111: count adjacent 1-pairs and done pulses over three periods
        repeat (3) @(negedge clk);
        d_a = 5'b11111; load_a = 1'b1;
        @(negedge clk);
        pairs = 0; dones = 0; prev = 1'b0;
        for (int k = 0; k < 3 * PER; k++) begin
            if (prev && outbits_a) pairs++;
            if (done_a) dones++;
            prev = outbits_a;
            if (k == 3 * PER - 1) load_a = 1'b0;
            @(negedge clk);
        end
        chk("held.pairs", 32'(pairs), 32'(3 * (4 + P)));
        chk("held.dones", 32'(dones), 32'd3);

        // GAP=0 instance, back-to-back words 10000 then 00011
        repeat (PER) @(negedge clk);
        d_b = 5'b10000; load_b = 1'b1;
        @(negedge clk);
        vb = '0; vv = '0;
        for (int k = 0; k < 14; k++) begin
            vb = {vb[12:0], outbits_b};
            vv = {vv[12:0], out_valid_b};
            if (k == 0) d_b = 5'b00011;
            if (k == 6 + P) load_b = 1'b0;
            @(negedge clk);
        end
        chk("gap0.outbits",   32'(vb), 32'(e_vb));
        chk("gap0.out_valid", 32'(vv), 32'(e_vv));

        // Random traffic on both instances, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            load_a  = ($urandom_range(2) == 0);
            d_a     = W'($urandom);
            reset_a = ($urandom_range(63) == 0);
            load_b  = ($urandom_range(2) == 0);
            d_b     = W'($urandom);
            reset_b = ($urandom_range(63) == 0);
            @(negedge clk);
        end
        reset_a = 1'b0; reset_b = 1'b0; load_a = 1'b0; load_b = 1'b0;
        repeat (PER + 2) @(negedge clk);
        chk("final.ready_a", 32'(ready_a), 32'd1);
        chk("final.ready_b", 32'(ready_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
